// File: rtl/xversat_swap_pkg.sv
// rtl/xversat_swap_pkg.sv - shared modes, lane widths, FSM states and lane-reverse helper
package xversat_swap_pkg;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_BYTE = 2'd1;
  localparam logic [1:0] MODE_HALF = 2'd2;
  localparam logic [1:0] MODE_PAIR = 2'd3;

  localparam int LANE_BYTE = 8;
  localparam int LANE_HALF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Source bit index for output bit bit_idx when lanes of lane_w bits are reversed
  function automatic int lane_rev_index(input int bit_idx, input int data_w, input int lane_w);
    int lanes;
    int lane;
    int offs;
    lanes = data_w / lane_w;
    lane  = bit_idx / lane_w;
    offs  = bit_idx % lane_w;
    return (lanes - 1 - lane) * lane_w + offs;
  endfunction

endpackage

// File: rtl/swap_lanes.sv
// rtl/swap_lanes.sv - combinational reversal of LANE_W-bit lanes within a DATA_W word
module swap_lanes
  import xversat_swap_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  // Pure wiring: each output bit picks its mirrored-lane source bit
  for (genvar g = 0; g < DATA_W; g++) begin : g_bit
    localparam int SRC = lane_rev_index(g, DATA_W, LANE_W);
    assign o_data[g] = i_data[SRC];
  end

endmodule

// File: rtl/swap_endian_stream.sv
// rtl/swap_endian_stream.sv - framed, registered lane-swap stream unit with pair swap
module swap_endian_stream
  import xversat_swap_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              running,
  output logic              done,
  input  logic              enabled,
  input  logic [1:0]        mode,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] in0,
  input  logic              in0_valid,
  output logic [DATA_W-1:0] out0,
  output logic              out0_valid
);

  state_t              r_state;
  state_t              w_state_next;
  logic [1:0]          r_mode;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_in_cnt;
  logic [LEN_W-1:0]    r_out_cnt;
  logic [DATA_W-1:0]   r_hold;
  logic [DATA_W-1:0]   r_pend;
  logic                r_pend_valid;
  logic [DATA_W-1:0]   r_out;
  logic                r_out_valid;
  logic                r_done;

  logic [DATA_W-1:0]   w_bswap_in;
  logic [DATA_W-1:0]   w_hswap_in;
  logic                w_accept;
  logic                w_last_in;
  logic                w_even;
  logic                w_emit;
  logic                w_emit_last;
  logic [DATA_W-1:0]   w_emit_data;
  logic                w_pend_load;
  logic [DATA_W-1:0]   w_pend_data;
  logic                w_hold_load;

  swap_lanes #(.DATA_W(DATA_W), .LANE_W(LANE_BYTE)) u_bswap (
    .i_data (in0),
    .o_data (w_bswap_in)
  );

  swap_lanes #(.DATA_W(DATA_W), .LANE_W(LANE_HALF)) u_hswap (
    .i_data (in0),
    .o_data (w_hswap_in)
  );

  assign w_accept    = (r_state == ST_RUN) && in0_valid && (r_in_cnt != r_len);
  assign w_last_in   = ((r_in_cnt + LEN_W'(1)) == r_len);
  assign w_even      = ~r_in_cnt[0];
  assign w_emit_last = w_emit && ((r_out_cnt + LEN_W'(1)) == r_len);

  // Output slot arbitration: a pending low word always wins; a trailing odd
  // word that collides with it is parked in the pending register instead.
  // Hold keeps word A already byte-swapped so only two swap units are needed.
  always_comb begin
    w_emit      = 1'b0;
    w_emit_data = '0;
    w_pend_load = 1'b0;
    w_pend_data = '0;
    w_hold_load = 1'b0;
    if (r_pend_valid) begin
      w_emit      = 1'b1;
      w_emit_data = r_pend;
    end
    if (w_accept) begin
      if (r_mode != MODE_PAIR) begin
        w_emit = 1'b1;
        case (r_mode)
          MODE_BYTE: w_emit_data = w_bswap_in;
          MODE_HALF: w_emit_data = w_hswap_in;
          default:   w_emit_data = in0;
        endcase
      end else if (!w_even) begin
        w_emit      = 1'b1;
        w_emit_data = w_bswap_in;
        w_pend_load = 1'b1;
        w_pend_data = r_hold;
      end else if (w_last_in) begin
        if (r_pend_valid) begin
          w_pend_load = 1'b1;
          w_pend_data = w_bswap_in;
        end else begin
          w_emit      = 1'b1;
          w_emit_data = w_bswap_in;
        end
      end else begin
        w_hold_load = 1'b1;
      end
    end
  end

  // Control FSM next state: run always restarts, inputs exhausted -> flush, done -> idle
  always_comb begin
    w_state_next = r_state;
    if (run) begin
      w_state_next = (length == '0) ? ST_IDLE : ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:   if (w_accept && w_last_in) w_state_next = ST_FLUSH;
        ST_FLUSH: if (r_done) w_state_next = ST_IDLE;
        default:  w_state_next = r_state;
      endcase
    end
  end

  // Control FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath: config latch, counters, hold/pending buffers and registered output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode       <= MODE_PASS;
      r_len        <= '0;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_hold       <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_done       <= 1'b0;
    end else if (run) begin
      r_mode       <= enabled ? mode : MODE_PASS;
      r_len        <= length;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_hold       <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_out_valid  <= 1'b0;
      r_done       <= (length == '0);
    end else begin
      if (w_accept) r_in_cnt <= r_in_cnt + LEN_W'(1);
      if (w_emit) begin
        r_out     <= w_emit_data;
        r_out_cnt <= r_out_cnt + LEN_W'(1);
      end
      if (w_hold_load) r_hold <= w_bswap_in;
      if (w_pend_load) r_pend <= w_pend_data;
      r_pend_valid <= w_pend_load;
      r_out_valid  <= w_emit;
      r_done       <= w_emit_last;
    end
  end

  assign running    = (r_state != ST_IDLE);
  assign done       = r_done;
  assign out0       = r_out;
  assign out0_valid = r_out_valid;

endmodule

// File: tb/tb_swap_endian_stream.sv
// tb/tb_swap_endian_stream.sv - randomized and directed self-checking bench for swap_endian_stream
module tb_swap_endian_stream;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b0;
  logic              running;
  logic              done;
  logic              enabled = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [LEN_W-1:0]  length = '0;
  logic [DATA_W-1:0] in0 = '0;
  logic              in0_valid = 1'b0;
  logic [DATA_W-1:0] out0;
  logic              out0_valid;

  swap_endian_stream #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .running    (running),
    .done       (done),
    .enabled    (enabled),
    .mode       (mode),
    .length     (length),
    .in0        (in0),
    .in0_valid  (in0_valid),
    .out0       (out0),
    .out0_valid (out0_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [31:0] d;
    int          c;
    bit          dn;
  } ent_t;
  ent_t log_q[$];

  // Reference model state: the frame as seen by the rules, not by the RTL
  int          m_len = 0;
  logic [1:0]  m_mode = 2'd0;
  logic [31:0] acc[$];
  int          oi = 0;
  bit          m_zero_done = 1'b0;
  logic [31:0] m_last = '0;
  int          done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] bsw(input logic [31:0] x);
    logic [31:0] r;
    r = {<<8{x}};
    return r;
  endfunction

  function automatic logic [31:0] hsw(input logic [31:0] x);
    logic [31:0] r;
    r = {<<16{x}};
    return r;
  endfunction

  // Is everything needed to produce output number k already accepted?
  function automatic bit avail(input int k);
    if (m_mode == 2'd3 && (k % 2) == 0 && (k + 1) < m_len) return (k + 1) < acc.size();
    return k < acc.size();
  endfunction

  function automatic logic [31:0] exp_word(input int k);
    case (m_mode)
      2'd0: return acc[k];
      2'd1: return bsw(acc[k]);
      2'd2: return hsw(acc[k]);
      default: begin
        if ((k % 2) == 1) return bsw(acc[k-1]);
        if ((k + 1) < m_len) return bsw(acc[k+1]);
        return bsw(acc[k]);
      end
    endcase
  endfunction

  always @(posedge clk) cyc++;

  // Model update on the same edges the DUT samples its inputs
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_len = 0; m_mode = 2'd0; acc.delete(); oi = 0; m_zero_done = 1'b0; m_last = '0;
    end else begin
      m_zero_done = 1'b0;
      if (run) begin
        m_mode = enabled ? mode : 2'd0;
        m_len  = int'(length);
        acc.delete();
        oi = 0;
        m_zero_done = (length == '0);
      end else if (in0_valid && acc.size() < m_len) begin
        acc.push_back(in0);
      end
    end
  end

  // Compare process: every cycle outside reset
  always @(negedge clk) begin : cmp
    logic [31:0] e;
    ent_t        en;
    bit          ed;
    if (!rst) begin
      ed = m_zero_done;
      if (out0_valid) begin
        if (oi >= m_len) begin
          chk("extra_out_valid", 32'(oi), 32'(m_len - 1));
        end else if (!avail(oi)) begin
          chk("out_before_input", 32'(oi), 32'(acc.size()));
        end else begin
          e = exp_word(oi);
          chk("out0_data", out0, e);
          m_last = e;
          ed = (oi == m_len - 1);
        end
        oi++;
        en.d = out0; en.c = cyc; en.dn = done;
        log_q.push_back(en);
      end else begin
        chk("out0_hold", out0, m_last);
      end
      chk("done", 32'(done), 32'(ed));
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input bit en, input logic [1:0] md, input int len);
    enabled = en; mode = md; length = LEN_W'(len); run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic send(input logic [31:0] x);
    in0 = x; in0_valid = 1'b1;
    tick();
    in0_valid = 1'b0;
  endtask

  task automatic wait_done(input int pre, input int budget);
    for (int i = 0; i < budget && done_cnt == pre; i++) tick();
    chk("frame_done_timeout", 32'(done_cnt > pre), 32'd1);
  endtask

  function automatic logic [31:0] logd(input int i);
    if (log_q.size() > i) return log_q[i].d;
    return 'x;
  endfunction

  function automatic int logc(input int i);
    if (log_q.size() > i) return log_q[i].c;
    return -1;
  endfunction

  initial begin : stim
    int pre;
    int c0;
    int lim;
    bit ab;
    tick(); tick();
    chk("rst_out0", out0, 32'd0);
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // Byte swap, length 3, back to back
    log_q.delete(); pre = done_cnt;
    start(1'b1, 2'd1, 3);
    send(32'h11223344); c0 = cyc;
    send(32'hAABBCCDD);
    send(32'h01020304);
    wait_done(pre, 10); tick();
    chk("m1_count", 32'(log_q.size()), 32'd3);
    chk("m1_w0", logd(0), 32'h44332211);
    chk("m1_w1", logd(1), 32'hDDCCBBAA);
    chk("m1_w2", logd(2), 32'h04030201);
    chk("m1_lat_first", 32'(logc(0)), 32'(c0));
    chk("m1_lat_last", 32'(logc(2)), 32'(c0 + 2));
    chk("m1_done_last", 32'(log_q.size() > 2 && log_q[2].dn), 32'd1);

    // Half-word mode, disabled then enabled
    log_q.delete(); pre = done_cnt;
    start(1'b0, 2'd2, 1); send(32'h11223344); wait_done(pre, 10);
    chk("m2_disabled", logd(0), 32'h11223344);
    log_q.delete(); pre = done_cnt;
    start(1'b1, 2'd2, 1); send(32'h11223344); wait_done(pre, 10);
    chk("m2_enabled", logd(0), 32'h33441122);
    tick();

    // Pair swap, length 5, back to back
    log_q.delete(); pre = done_cnt;
    start(1'b1, 2'd3, 5);
    send(32'h1); send(32'h2); c0 = cyc;
    send(32'h3); send(32'h4); send(32'h5);
    for (int j = 0; j < 10 && !done; j++) tick();
    chk("m3_running_at_done", 32'(running), 32'd1);
    tick();
    chk("m3_running_fall", 32'(running), 32'd0);
    chk("m3_w0", logd(0), 32'h02000000);
    chk("m3_w1", logd(1), 32'h01000000);
    chk("m3_w2", logd(2), 32'h04000000);
    chk("m3_w3", logd(3), 32'h03000000);
    chk("m3_w4", logd(4), 32'h05000000);
    chk("m3_first_cycle", 32'(logc(0)), 32'(c0));
    chk("m3_no_gaps", 32'(logc(4)), 32'(c0 + 4));
    chk("m3_done_on_tail", 32'(log_q.size() > 4 && log_q[4].dn), 32'd1);

    // Zero length
    pre = done_cnt;
    start(1'b1, 2'd1, 0);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_running", 32'(running), 32'd0);
    tick();
    chk("len0_done_fall", 32'(done), 32'd0);
    chk("len0_running_after", 32'(running), 32'd0);
    chk("len0_one_done", 32'(done_cnt), 32'(pre + 1));

    // Abort after one of four words
    pre = done_cnt;
    start(1'b1, 2'd1, 4); send(32'hDEADBEEF);
    start(1'b1, 2'd1, 4);
    for (int i = 0; i < 4; i++) send(32'h10 + 32'(i));
    wait_done(pre, 10); tick(); tick();
    chk("abort_single_done", 32'(done_cnt), 32'(pre + 1));

    // Config change mid-frame and extra valids
    log_q.delete(); pre = done_cnt;
    start(1'b1, 2'd1, 4);
    send(32'h12345678); send(32'h9ABCDEF0);
    mode = 2'd0; enabled = 1'b0;
    send(32'h0BADF00D); send(32'hCAFEBABE);
    for (int i = 0; i < 3; i++) send(32'h77777777);
    tick(); tick(); tick();
    chk("cfg_count", 32'(log_q.size()), 32'd4);
    chk("cfg_w2", logd(2), 32'h0DF0AD0B);
    chk("cfg_w3", logd(3), 32'hBEBAFECA);
    chk("cfg_one_done", 32'(done_cnt), 32'(pre + 1));

    // Reset mid-frame in pair mode after word A
    start(1'b1, 2'd3, 4); send(32'h00000001);
    rst = 1'b1; #1;
    chk("rstmid_running", 32'(running), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_out0", out0, 32'd0);
    chk("rstmid_out0_valid", 32'(out0_valid), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send($urandom);
      chk("post_rst_no_valid", 32'(out0_valid), 32'd0);
      chk("post_rst_idle", 32'(running), 32'd0);
    end

    // Randomized frames, with occasional aborts and idle gaps
    for (int f = 0; f < 80; f++) begin
      pre = done_cnt;
      ab  = ($urandom % 8) == 0;
      start(($urandom % 4) != 0, 2'($urandom % 4), $urandom_range(0, 9));
      lim = ab ? $urandom_range(0, 4) : 300;
      for (int i = 0; i < lim && acc.size() < m_len; i++) begin
        in0_valid = ($urandom % 4) != 0;
        in0 = $urandom;
        tick();
      end
      in0_valid = 1'b0;
      if (!ab) wait_done(pre, 20);
      if (($urandom % 3) == 0) tick();
    end

    // Maximum length completes
    pre = done_cnt;
    start(1'b1, 2'd3, 65535);
    in0_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in0 = $urandom;
      tick();
    end
    in0_valid = 1'b0;
    wait_done(pre, 10);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
